// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: byte FIFO behind a serial receiver. Valid frames (stop bit 1)
// are queued. Frames with a bad stop bit, and valid frames that arrive while
// the FIFO is full and not being drained, are dropped and counted. The error
// flags stay set until clr_err.
module rx_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     sir_saved,
  input  logic [8:0]               sir,
  output logic [7:0]               dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     frame_err,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  input  logic                     clr_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic frame_ok;
  logic frame_bad;
  logic pop;
  logic push;
  logic ovf_event;
  logic drop_event;

  // Status outputs come only from registered state, so no input reaches them combinationally.
  assign dout_valid = (count != '0);
  assign full       = (count == CW'(DEPTH));
  assign dout       = dout_valid ? mem[rd_ptr] : 8'h00;

  // Classify this cycle's frame and decide whether to push, pop or drop.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch can be inferred.
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    pop        = 1'b0;
    push       = 1'b0;
    ovf_event  = 1'b0;
    drop_event = 1'b0;
    if (sir_saved) begin
      frame_ok  = sir[8];
      frame_bad = ~sir[8];
    end
    pop = dout_valid && dout_ready;
    if (frame_ok) begin
      // When the FIFO is full, a same-cycle pop frees the slot being written.
      if (!full || pop) push = 1'b1;
      else              ovf_event = 1'b1;
    end
    drop_event = ovf_event || frame_bad;
  end

  // Storage array. Only the pointers and count are reset.
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset. The reset count makes stale entries
    // unreachable, so clearing the array would be wasted logic.
    if (push) mem[wr_ptr] <= sir[7:0];
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples its pre-edge inputs regardless of statement order.
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags and saturating drop counter. A new error wins over clr_err.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= 8'h00;
    end else if (clr_err) begin
      frame_err <= frame_bad;
      overflow  <= ovf_event;
      drop_cnt  <= drop_event ? 8'h01 : 8'h00;
    end else begin
      if (frame_bad) frame_err <= 1'b1;
      if (ovf_event) overflow  <= 1'b1;
      if (drop_event && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'h01;
    end
  end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// tb_rx_byte_fifo: directed and randomized scenarios for rx_byte_fifo. A
// queue-based reference model supplies every expected value.
module tb_rx_byte_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic       sir_saved;
  logic [8:0] sir;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [3:0] count;
  logic       full;
  logic       frame_err;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic       clr_err;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0] mq[$];
  logic       m_ferr;
  logic       m_ovf;
  int         m_drop;

  rx_byte_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .sir_saved(sir_saved), .sir(sir),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .count(count), .full(full), .frame_err(frame_err), .overflow(overflow),
    .drop_cnt(drop_cnt), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  // Apply the receiver rules to one clock cycle.
  task automatic model_step(input logic sv, input logic [8:0] fr,
                            input logic rdy, input logic clr);
    bit pop, push, ovf_ev, fe_ev;
    pop = (mq.size() != 0) && rdy;
    push = 0; ovf_ev = 0; fe_ev = 0;
    if (sv) begin
      if (fr[8]) begin
        if (mq.size() < DEPTH || pop) push = 1;
        else ovf_ev = 1;
      end else fe_ev = 1;
    end
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(fr[7:0]);
    if (clr) begin
      m_ferr = fe_ev;
      m_ovf  = ovf_ev;
      m_drop = (fe_ev || ovf_ev) ? 1 : 0;
    end else begin
      if (fe_ev)  m_ferr = 1'b1;
      if (ovf_ev) m_ovf  = 1'b1;
      if ((fe_ev || ovf_ev) && m_drop < 255) m_drop++;
    end
  endtask

  // Drive one clock cycle of stimulus and return 1 ns after the edge.
  task automatic cycle(input logic sv, input logic [8:0] fr,
                       input logic rdy, input logic clr);
    sir_saved = sv; sir = fr; dout_ready = rdy; clr_err = clr;
    model_step(sv, fr, rdy, clr);
    @(posedge clk); #1;
    sir_saved = 1'b0; dout_ready = 1'b0; clr_err = 1'b0;
  endtask

  function automatic logic [7:0] m_head();
    return (mq.size() != 0) ? mq[0] : 8'h00;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; sir_saved = 1'b0; sir = '0; dout_ready = 1'b0; clr_err = 1'b0;
    model_reset();
    #2;
    checks++; if (count !== 4'd0)      begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
    checks++; if (dout !== 8'h00)      begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
    checks++; if ({full, frame_err, overflow} !== 3'b000 || drop_cnt !== 8'h00) begin
      errors++; $display("FAIL reset_flags: got full=%b fe=%b ovf=%b drop=%0d want all 0", full, frame_err, overflow, drop_cnt); end
    // A frame pulse while reset is held must be ignored.
    @(negedge clk); sir_saved = 1'b1; sir = 9'h123;
    @(posedge clk); #1; sir_saved = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_ignore_push: got %0d want 0", count); end
    // The first edge after release accepts a frame.
    rstn = 1'b1;
    cycle(1'b1, 9'h13C, 1'b0, 1'b0);
    checks++; if (count !== 4'd1 || dout !== 8'h3C) begin
      errors++; $display("FAIL reset_first_edge: got count=%0d dout=%h want 1/3c", count, dout); end
    cycle(1'b0, 9'h0, 1'b1, 1'b0);
  endtask

  task automatic test_single();
    cycle(1'b1, 9'h141, 1'b0, 1'b0);
    checks++; if (dout_valid !== 1'b1 || dout !== 8'h41 || count !== 4'd1) begin
      errors++; $display("FAIL single_push: got v=%b dout=%h count=%0d want 1/41/1", dout_valid, dout, count); end
    cycle(1'b0, 9'h0, 1'b1, 1'b0);
    checks++; if (count !== 4'd0 || dout !== 8'h00 || dout_valid !== 1'b0) begin
      errors++; $display("FAIL single_pop: got v=%b dout=%h count=%0d want 0/00/0", dout_valid, dout, count); end
    // dout_ready on an empty FIFO must not underflow.
    cycle(1'b0, 9'h0, 1'b1, 1'b0);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL empty_pop: got %0d want 0", count); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 8; i++) cycle(1'b1, {1'b1, 8'(i)}, 1'b0, 1'b0);
    cycle(1'b1, 9'h1AA, 1'b0, 1'b0);
    checks++; if (full !== 1'b1 || overflow !== 1'b1 || drop_cnt !== 8'd1 || count !== 4'd8) begin
      errors++; $display("FAIL overflow: got full=%b ovf=%b drop=%0d count=%0d want 1/1/1/8", full, overflow, drop_cnt, count); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (dout !== 8'(i) || dout !== m_head()) begin
        errors++; $display("FAIL overflow_order: got %h want %h", dout, 8'(i)); end
      cycle(1'b0, 9'h0, 1'b1, 1'b0);
    end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL overflow_drain: got %0d want 0", count); end
    cycle(1'b0, 9'h0, 1'b0, 1'b1);
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) cycle(1'b1, {1'b1, 8'(8'h10 + i)}, 1'b0, 1'b0);
    cycle(1'b1, 9'h155, 1'b1, 1'b0);
    checks++; if (count !== 4'd8 || overflow !== 1'b0 || full !== 1'b1) begin
      errors++; $display("FAIL full_push_pop: got count=%0d ovf=%b want 8/0", count, overflow); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (dout !== m_head()) begin
        errors++; $display("FAIL full_push_pop_order: got %h want %h", dout, m_head()); end
      if (i == 7) begin
        checks++; if (dout !== 8'h55) begin errors++; $display("FAIL full_push_pop_last: got %h want 55", dout); end
      end
      cycle(1'b0, 9'h0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_frame_err();
    cycle(1'b1, 9'h141, 1'b0, 1'b0);
    cycle(1'b1, 9'h0FF, 1'b0, 1'b0);
    checks++; if (frame_err !== 1'b1 || drop_cnt !== 8'd1 || count !== 4'd1 || dout !== 8'h41) begin
      errors++; $display("FAIL frame_err: got fe=%b drop=%0d count=%0d dout=%h want 1/1/1/41", frame_err, drop_cnt, count, dout); end
    cycle(1'b0, 9'h0, 1'b0, 1'b1);
    checks++; if (frame_err !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 8'd0 || count !== 4'd1) begin
      errors++; $display("FAIL clr_err: got fe=%b ovf=%b drop=%0d count=%0d want 0/0/0/1", frame_err, overflow, drop_cnt, count); end
    cycle(1'b1, 9'h0FF, 1'b0, 1'b0);
    cycle(1'b1, 9'h033, 1'b0, 1'b1);
    checks++; if (frame_err !== 1'b1 || drop_cnt !== 8'd1) begin
      errors++; $display("FAIL clr_vs_err: got fe=%b drop=%0d want 1/1", frame_err, drop_cnt); end
    cycle(1'b0, 9'h0, 1'b1, 1'b1);
  endtask

  task automatic test_saturate_and_async_reset();
    for (int i = 0; i < 300; i++) cycle(1'b1, {1'b0, 8'($urandom)}, 1'b0, 1'b0);
    checks++; if (drop_cnt !== 8'hFF || drop_cnt !== 8'(m_drop)) begin
      errors++; $display("FAIL drop_saturate: got %0d want 255", drop_cnt); end
    for (int i = 0; i < 5; i++) cycle(1'b1, {1'b1, 8'($urandom)}, 1'b0, 1'b0);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL pre_reset_count: got %0d want 5", count); end
    // Assert reset between edges: outputs must clear without a clock edge.
    #2 rstn = 1'b0; model_reset();
    #1;
    checks++; if (count !== 4'd0 || dout_valid !== 1'b0 || dout !== 8'h00 || full !== 1'b0 ||
                  frame_err !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 8'h00) begin
      errors++; $display("FAIL async_reset: got count=%0d v=%b dout=%h full=%b fe=%b ovf=%b drop=%0d want all 0",
                         count, dout_valid, dout, full, frame_err, overflow, drop_cnt); end
    @(posedge clk); #1; rstn = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) cycle(1'b1, {1'b1, 8'($urandom)}, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      checks++; if (dout !== m_head()) begin errors++; $display("FAIL b2b_order: got %h want %h", dout, m_head()); end
      cycle(1'b1, {1'b1, 8'($urandom)}, 1'b1, 1'b0);
      checks++; if (count !== 4'd4) begin errors++; $display("FAIL b2b_count: got %0d want 4", count); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (dout !== m_head()) begin errors++; $display("FAIL b2b_drain: got %h want %h", dout, m_head()); end
      cycle(1'b0, 9'h0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic sv, rdy, clr;
      logic [8:0] fr;
      sv  = ($urandom_range(0, 99) < 60);
      fr  = {($urandom_range(0, 9) != 0), 8'($urandom)};
      rdy = ($urandom_range(0, 99) < 45);
      clr = ($urandom_range(0, 99) < 5);
      cycle(sv, fr, rdy, clr);
      checks++;
      if (count !== 4'(mq.size()) || dout !== m_head() || dout_valid !== (mq.size() != 0) ||
          full !== (mq.size() == DEPTH) || frame_err !== m_ferr || overflow !== m_ovf ||
          drop_cnt !== 8'(m_drop)) begin
        errors++;
        $display("FAIL random[%0d]: got count=%0d dout=%h fe=%b ovf=%b drop=%0d want count=%0d dout=%h fe=%b ovf=%b drop=%0d",
                 i, count, dout, frame_err, overflow, drop_cnt, mq.size(), m_head(), m_ferr, m_ovf, m_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_frame_err();
    test_saturate_and_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_byte_fifo.md
RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count; power of two, 2..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sir_saved  input  1  one-cycle pulse: receiver frame complete.
REQ-005 SHALL have port sir  input  9  received frame; [8] stop bit, [7:0] data byte, LSB first on the line.
REQ-006 SHALL have port dout  output  8  head-of-FIFO byte.
REQ-007 SHALL have port dout_valid  output  1  FIFO non-empty; dout is meaningful.
REQ-008 SHALL have port dout_ready  input  1  consumer accepts dout this cycle.
REQ-009 SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-010 SHALL have port full  output  1  count == DEPTH.
REQ-011 SHALL have port frame_err  output  1  sticky: a frame with stop bit 0 was received.
REQ-012 SHALL have port overflow  output  1  sticky: a valid byte was dropped because the FIFO was full.
REQ-013 SHALL have port drop_cnt  output  8  saturating count of dropped frames, from both error causes.
REQ-014 SHALL have port clr_err  input  1  synchronous clear of frame_err, overflow and drop_cnt.

Function
REQ-015 SHALL sample sir only in cycles where sir_saved is 1 and ignore sir otherwise.
REQ-016 SHALL treat a sampled frame with sir[8]==1 as valid and with sir[8]==0 as a framing error.
REQ-017 SHALL write a valid frame's sir[7:0] at wr_ptr when the push is accepted, then advance wr_ptr modulo DEPTH.
REQ-018 SHALL define a pop as dout_valid && dout_ready; a pop advances rd_ptr modulo DEPTH.
REQ-019 SHALL accept a push when not full, or when full with a pop in the same cycle; count is then unchanged.
REQ-020 SHALL, on a valid frame arriving while full with no pop, drop the byte, set overflow, and increment drop_cnt.
REQ-021 SHALL, on a framing-error frame, discard it, set frame_err, increment drop_cnt, and leave FIFO contents unchanged.
REQ-022 SHALL update count by +1 on push only, -1 on pop only, and 0 on push+pop or neither.
REQ-023 SHALL drive dout_valid = (count != 0) and full = (count == DEPTH) directly from state with no combinational path from inputs.
REQ-024 SHALL drive dout = mem[rd_ptr] when dout_valid, and 8'h00 when empty.
REQ-025 SHALL give no fall-through: a byte pushed into an empty FIFO appears with dout_valid=1 one cycle after the sir_saved pulse.
REQ-026 SHALL ignore dout_ready while empty; count never underflows.
REQ-027 SHALL saturate drop_cnt at 8'hFF.
REQ-028 SHALL let a same-cycle new error take priority over clr_err: the flag is set and drop_cnt becomes 1.
REQ-029 SHALL leave FIFO data, pointers and count unaffected by clr_err.
REQ-030 SHALL keep the flags and drop_cnt independent of pushes and pops except as stated above.

Reset
REQ-031 SHALL, while rstn is 0, force rd_ptr=0, wr_ptr=0, count=0, dout_valid=0, dout=8'h00, full=0, frame_err=0, overflow=0, drop_cnt=0, regardless of clk.
REQ-032 SHALL discard buffered bytes when reset is asserted mid-operation; storage contents need not be cleared.
REQ-033 SHALL ignore a sir_saved pulse coincident with rstn low.
REQ-034 SHALL accept a sir_saved pulse on the first rising clk edge after rstn deasserts.

Verification
REQ-035 Bench SHALL cover: sir=9'h141 pulse into empty FIFO -> next cycle dout_valid=1, dout=8'h41, count=1; pop with dout_ready=1 -> count=0, dout=8'h00.
REQ-036 Bench SHALL cover: 8 valid frames 8'h00..8'h07 with DEPTH=8, then a 9th frame 9'h1AA -> full=1, overflow=1, drop_cnt=1, then 8 pops return 00..07 in order.
REQ-037 Bench SHALL cover: full FIFO plus sir_saved (9'h155) and dout_ready=1 in the same cycle -> count stays 8, overflow=0, 8'h55 is popped last.
REQ-038 Bench SHALL cover: sir=9'h0FF pulse (stop bit 0) -> frame_err=1, drop_cnt=1, count unchanged; clr_err alone -> flags 0; clr_err with another bad frame in the same cycle -> frame_err=1, drop_cnt=1.
REQ-039 Bench SHALL cover: 300 bad frames -> drop_cnt=8'hFF; rstn pulse low mid-stream with count=5 -> all outputs at reset values immediately, without waiting for a clk edge.
REQ-040 Bench SHALL cover: 20 continuous push/pop cycles exercising pointer wrap -> output order matches input order, count stable.
